obstacle_scheduler: RTL and testbench
=====================================

Name: obstacle_scheduler

Overview:
- Sequencer that drives the select input of obstacle_mux_16_to_1 from game state, replacing the manual sw[3:0] selection.
- Cycles through the implemented obstacles, holding each for a fixed number of frames, with gap periods between them.
- Emits an active flag so the collision and HP path can ignore the gaps.
- Sits in the pclk domain between draw_background (play_selected, vsync_out) and the obstacle mux / colision_detector.

Parameters:
- NUM_OBSTACLES, 2, number of populated mux inputs; legal range 1..16; indices 0..NUM_OBSTACLES-1.
- FRAMES_PER_OBSTACLE, 300, frames each obstacle stays active; legal range 1..4095.
- GAP_FRAMES, 60, frames of inactivity before each obstacle, including the first; legal range 1..4095.
- RANDOM_ORDER, 0, 0 = sequential order, 1 = LFSR-based order.

Ports:
- pclk  in  1  pixel clock, 65 MHz.
- rst  in  1  asynchronous active-high reset.
- vsync_in  in  1  vertical sync from draw_background; its rising edge is the frame tick.
- play_selected  in  1  game in progress.
- game_over  in  1  level; halts the schedule.
- victory  in  1  level; halts the schedule.
- override_en  in  1  when 1, obstacle_select follows sw_override.
- sw_override  in  4  manual select from the board switches.
- obstacle_select  out  4  mux select.
- obstacle_active  out  1  high while the current obstacle is live.
- obstacle_start  out  1  one-cycle pulse on GAP->ACTIVE entry; used to restart obstacle animation.
- round_count  out  8  completed full passes through the obstacle list; saturates at 255.

Behaviour:
- Clock and reset
  - All registers are on posedge pclk or posedge rst.
  - Reset values: state IDLE, obstacle_select 0, obstacle_active 0, obstacle_start 0, round_count 0, frame_cnt 0, idx 0, LFSR 8'hA5.
- Frame tick
  - vsync_q is vsync_in registered; tick = vsync_in & ~vsync_q.
  - vsync_q resets to 1, so no tick is generated on the first cycle after reset.
- State machine; frame_cnt is 12 bits and increments on each tick.
  - IDLE: outputs inactive. On play_selected=1 and no halt: go to GAP, frame_cnt=0, idx=0, round_count=0.
  - GAP: obstacle_active=0. On the tick where frame_cnt==GAP_FRAMES-1: go to ACTIVE, frame_cnt=0, pulse obstacle_start for 1 cycle.
  - ACTIVE: obstacle_active=1. On the tick where frame_cnt==FRAMES_PER_OBSTACLE-1: go to GAP, frame_cnt=0, and compute the next idx.
  - HALT: entered from GAP or ACTIVE when game_over|victory. obstacle_active=0, counters frozen. Exits to IDLE when play_selected=0.
- Next-index rule
  - Sequential: idx+1, wrapping to 0 at NUM_OBSTACLES-1. On wrap, round_count increments (saturating).
  - RANDOM_ORDER=1: the LFSR (x^8+x^6+x^5+x^4+1) advances on every tick. Candidate = lfsr[3:0]. If candidate < NUM_OBSTACLES and candidate != idx, it is used; otherwise the sequential rule applies. round_count increments whenever the chosen idx is less than or equal to the old idx.
- Priority, highest first:
  1. rst
  2. game_over|victory (-> HALT)
  3. play_selected falling (-> IDLE from any state)
  4. tick
- Simultaneous events: a halt and a tick in the same cycle produce HALT, and the tick is ignored.
- Output timing
  - obstacle_select is registered: in normal mode it equals idx, 1-cycle latency after the idx change.
  - override_en=1: obstacle_select = sw_override on the next cycle, obstacle_active forced to 1, and the FSM keeps running unseen.
  - When override_en drops, the output returns to idx on the next cycle.
- Edge cases
  - NUM_OBSTACLES=1: idx stays 0, and round_count increments after every ACTIVE period.
  - Reset mid-ACTIVE: all outputs return to reset values asynchronously. No obstacle_start pulse is emitted.

Decomposition:
- Shared header obstacle_defs.vh:
  - FSM state encodings ST_IDLE=2'd0, ST_GAP=2'd1, ST_ACTIVE=2'd2, ST_HALT=2'd3.
  - SEL_W=4.
  - LFSR seed and taps.
- One sub-module, frame_tick_gen: vsync edge detector producing the tick, with its own pclk/rst. It is reusable by the obstacle modules.

Test Plan (FRAMES_PER_OBSTACLE=4, GAP_FRAMES=2, NUM_OBSTACLES=2, RANDOM_ORDER=0; vsync toggled every 20 cycles):
- Reset release, then play_selected=1:
  - obstacle_active=0 for 2 ticks.
  - Then obstacle_start is a single 1-cycle pulse and select=0, active=1 for 4 ticks.
  - Then a 2-tick gap, then select=1.
- Run 3 full passes: round_count goes 0->1->2->3, incrementing exactly when idx wraps 1->0.
- game_over asserted on the same cycle as a tick during ACTIVE:
  - Next cycle state=HALT, active=0, select held at its current value.
  - play_selected=0 then gives IDLE. A new play_selected=1 restarts with round_count=0.
- override_en=1 with sw_override=4'd7 mid-GAP:
  - Next cycle select=7, active=1.
  - Release: select returns to the FSM idx and the FSM tick count is unaffected.
- Assert rst mid-ACTIVE for 1 cycle, asynchronously between clock edges: all outputs go to 0 immediately, and no tick or start pulse occurs on the first cycle after release.
- RANDOM_ORDER=1, NUM_OBSTACLES=3, 50 ACTIVE periods: select is always <3, never repeats consecutively, and round_count is consistent with the wrap rule.

Source files
------------

// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the obstacle scheduler: FSM states, widths and LFSR constants.
package obstacle_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam int unsigned SEL_W   = 4;
  localparam int unsigned FRAME_W = 12;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3).
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obstacle_scheduler_tick.sv
// Frame tick generator: one-cycle pulse on each rising edge of vsync.
module frame_tick_gen (
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
  output logic tick
);

  logic vsync_q;

  // Registered vsync; resets high so the first cycle after reset never ticks.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) vsync_q <= 1'b1;
    else     vsync_q <= vsync_in;
  end

  assign tick = vsync_in & ~vsync_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: sequences the obstacle mux select through gap/active
// periods counted in frames, with halt, manual override and round counting.
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int unsigned NUM_OBSTACLES       = 2,
  parameter int unsigned FRAMES_PER_OBSTACLE = 300,
  parameter int unsigned GAP_FRAMES          = 60,
  parameter int unsigned RANDOM_ORDER        = 0
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync_in,
  input  logic             play_selected,
  input  logic             game_over,
  input  logic             victory,
  input  logic             override_en,
  input  logic [SEL_W-1:0] sw_override,
  output logic [SEL_W-1:0] obstacle_select,
  output logic             obstacle_active,
  output logic             obstacle_start,
  output logic [7:0]       round_count
);

  localparam logic [SEL_W:0]   NUM_L    = (SEL_W + 1)'(NUM_OBSTACLES);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_OBSTACLES - 1);
  localparam logic [FRAME_W-1:0] GAP_LAST = FRAME_W'(GAP_FRAMES - 1);
  localparam logic [FRAME_W-1:0] ACT_LAST = FRAME_W'(FRAMES_PER_OBSTACLE - 1);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [7:0]         round_q, round_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               act_q, act_d;
  logic               start_q, start_d;

  logic               tick;
  logic               halt;
  logic [SEL_W-1:0]   seq_idx;
  logic [SEL_W-1:0]   cand;
  logic [SEL_W-1:0]   nxt_idx;

  frame_tick_gen u_tick (
    .pclk     (pclk),
    .rst      (rst),
    .vsync_in (vsync_in),
    .tick     (tick)
  );

  assign halt = game_over | victory;

  // Next obstacle index: LFSR candidate when usable, otherwise sequential.
  always_comb begin
    seq_idx = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    cand    = lfsr_q[SEL_W-1:0];
    nxt_idx = seq_idx;
    if ((RANDOM_ORDER != 0) && ({1'b0, cand} < NUM_L) && (cand != idx_q))
      nxt_idx = cand;
  end

  // Schedule FSM: next state, counters and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    round_d = round_q;
    start_d = 1'b0;
    lfsr_d  = tick ? lfsr_step(lfsr_q) : lfsr_q;

    case (state_q)
      ST_IDLE: begin
        if (play_selected && !halt) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          idx_d   = '0;
          round_d = '0;
        end
      end
      ST_GAP, ST_ACTIVE: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (!play_selected) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (state_q == ST_GAP) begin
            if (cnt_q == GAP_LAST) begin
              state_d = ST_ACTIVE;
              cnt_d   = '0;
              start_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            if (cnt_q == ACT_LAST) begin
              state_d = ST_GAP;
              cnt_d   = '0;
              idx_d   = nxt_idx;
              // A non-increasing index means the list was wrapped.
              if ((nxt_idx <= idx_q) && (round_q != '1))
                round_d = round_q + 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      ST_HALT: begin
        if (!play_selected) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    act_d = override_en | (state_d == ST_ACTIVE);
    sel_d = override_en ? sw_override : idx_q;
  end

  // State, counters and output registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      round_q <= '0;
      lfsr_q  <= LFSR_SEED;
      sel_q   <= '0;
      act_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      lfsr_q  <= lfsr_d;
      sel_q   <= sel_d;
      act_q   <= act_d;
      start_q <= start_d;
    end
  end

  assign obstacle_select = sel_q;
  assign obstacle_active = act_q;
  assign obstacle_start  = start_q;
  assign round_count     = round_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Testbench for obstacle_scheduler: directed sequence plus random override,
// checked against a frame-level model; a second random-order instance is
// checked for range, non-repetition and wrap counting.
module tb_obstacle_scheduler;

  localparam int FR = 4;
  localparam int GP = 2;
  localparam int N  = 2;

  localparam int M_IDLE   = 0;
  localparam int M_GAP    = 1;
  localparam int M_ACTIVE = 2;
  localparam int M_HALT   = 3;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic       rst, rst2, vsync_in, play, go, vic, ov, play2;
  logic [3:0] sw;
  logic [3:0] sel;
  logic       act, start;
  logic [7:0] round;
  logic       zero1;
  logic [3:0] zero4;
  logic [3:0] sel2;
  logic       act2, start2;
  logic [7:0] round2;

  obstacle_scheduler #(
    .NUM_OBSTACLES(N), .FRAMES_PER_OBSTACLE(FR), .GAP_FRAMES(GP), .RANDOM_ORDER(0)
  ) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .play_selected(play),
    .game_over(go), .victory(vic), .override_en(ov), .sw_override(sw),
    .obstacle_select(sel), .obstacle_active(act), .obstacle_start(start),
    .round_count(round)
  );

  obstacle_scheduler #(
    .NUM_OBSTACLES(3), .FRAMES_PER_OBSTACLE(4), .GAP_FRAMES(2), .RANDOM_ORDER(1)
  ) dut2 (
    .pclk(pclk), .rst(rst2), .vsync_in(vsync_in), .play_selected(play2),
    .game_over(zero1), .victory(zero1), .override_en(zero1), .sw_override(zero4),
    .obstacle_select(sel2), .obstacle_active(act2), .obstacle_start(start2),
    .round_count(round2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Frame-level model of the schedule.
  int m_mode, m_rem, m_idx, m_round;
  bit m_vs_prev;
  int e_sel, e_act, e_start;

  int prev2   = -1;
  int exp_r2  = 0;
  int periods2 = 0;

  function automatic bit vs_of(input int c);
    return ((c / 20) % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_rem = 0; m_idx = 0; m_round = 0; m_vs_prev = 1'b1;
    e_sel = 0; e_act = 0; e_start = 0;
  endtask

  task automatic model_edge(input bit vs);
    bit tick;
    bit halt;
    int old;
    tick = vs && !m_vs_prev;
    m_vs_prev = vs;
    old = m_idx;
    halt = go || vic;
    e_start = 0;
    case (m_mode)
      M_IDLE: if (play && !halt) begin
        m_mode = M_GAP; m_rem = GP; m_idx = 0; m_round = 0;
      end
      M_GAP, M_ACTIVE: begin
        if (halt) m_mode = M_HALT;
        else if (!play) m_mode = M_IDLE;
        else if (tick) begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_mode == M_GAP) begin
              m_mode = M_ACTIVE; m_rem = FR; e_start = 1;
            end else begin
              m_mode = M_GAP; m_rem = GP;
              m_idx = (m_idx + 1) % N;
              if (m_idx == 0 && m_round < 255) m_round++;
            end
          end
        end
      end
      default: if (!play) m_mode = M_IDLE;
    endcase
    e_act = ov ? 1 : ((m_mode == M_ACTIVE) ? 1 : 0);
    e_sel = ov ? int'(sw) : old;
  endtask

  task automatic step();
    vsync_in = vs_of(cyc);
    @(posedge pclk);
    cyc++;
    if (rst) model_reset();
    else model_edge(vsync_in);
    #1;
    chk("select", 32'(sel), e_sel);
    chk("active", 32'(act), e_act);
    chk("start", 32'(start), e_start);
    chk("round", 32'(round), m_round);
    if (start2) begin
      periods2++;
      chk("r2_sel_lt3", 32'(sel2 < 4'd3), 1);
      if (prev2 >= 0) begin
        chk("r2_norepeat", 32'(int'(sel2) != prev2), 1);
        if (int'(sel2) <= prev2 && exp_r2 < 255) exp_r2++;
      end
      chk("r2_round", 32'(round2), exp_r2);
      prev2 = int'(sel2);
    end
  endtask

  logic [3:0] sel_before;

  initial begin
    rst = 1'b1; rst2 = 1'b1; play = 1'b0; play2 = 1'b0; go = 1'b0; vic = 1'b0;
    ov = 1'b0; sw = '0; vsync_in = 1'b0; zero1 = 1'b0; zero4 = '0;
    model_reset();
    #12;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_active", 32'(act), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_round", 32'(round), 0);
    step(); step();
    rst = 1'b0; rst2 = 1'b0;
    play = 1'b1; play2 = 1'b1;

    // Three full passes through the list.
    for (int i = 0; i < 4000 && m_round < 3; i++) step();
    chk("three_passes", 32'(round), 3);

    // Halt on the same cycle as a tick during ACTIVE.
    for (int i = 0; i < 2000 && !(m_mode == M_ACTIVE && vs_of(cyc) && !vs_of(cyc - 1)); i++) step();
    chk("halt_setup", m_mode, M_ACTIVE);
    sel_before = sel;
    go = 1'b1;
    step();
    chk("halt_active", 32'(act), 0);
    chk("halt_sel_held", 32'(sel), 32'(sel_before));
    repeat (50) step();
    play = 1'b0;
    step();
    go = 1'b0;
    step();
    play = 1'b1;
    step();
    chk("restart_round", 32'(round), 0);

    // Override during a gap.
    for (int i = 0; i < 2000 && m_mode != M_GAP; i++) step();
    ov = 1'b1; sw = 4'd7;
    step();
    chk("ovr_sel", 32'(sel), 7);
    chk("ovr_active", 32'(act), 1);
    repeat (60) step();
    ov = 1'b0;
    repeat (300) step();

    // Random override traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) ov = ~ov;
      sw = 4'($urandom_range(0, 15));
      step();
    end
    ov = 1'b0;
    repeat (100) step();

    // Asynchronous reset in the middle of ACTIVE.
    for (int i = 0; i < 2000 && m_mode != M_ACTIVE; i++) step();
    step();
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_sel", 32'(sel), 0);
    chk("async_rst_active", 32'(act), 0);
    chk("async_rst_start", 32'(start), 0);
    chk("async_rst_round", 32'(round), 0);
    model_reset();
    step();
    #2;
    rst = 1'b0;
    step();
    chk("post_rst_start", 32'(start), 0);
    repeat (200) step();

    // Let the random-order instance complete 50 active periods.
    for (int i = 0; i < 20000 && periods2 < 50; i++) step();
    chk("r2_periods", 32'(periods2 >= 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
